aurora_tx_scheduler: RTL
========================

Name: aurora_tx_scheduler

Overview:
- Upstream request generator for the Aurora 64b/66b multilane TX priority mux.
- Drives the mux's 8-bit ToSend request vector. Consumes the mux's one-hot Sent acknowledge.
- Owns the lane init sequence: not-ready, then channel bonding, then run.
- In run, schedules periodic clock-compensation (CC) bursts and forwards user data and user-K requests.
- Bit positions follow the shared aurora_definitions macros: CLOCK_COMPENSATION, NOT_READY, CHANNEL_BONDING, NATIVE_FLOW_CONTROL, USER_FLOW_CONTROL, USER_KBLOCKS, USER_DATA, IDLE.

Parameters:
- INIT_NR_BLOCKS, 64: number of NOT_READY blocks sent before bonding (1..65535).
- CB_BLOCKS, 16: number of CHANNEL_BONDING blocks sent before run (1..65535).
- CC_INTERVAL, 1000: blocks sent in run between starts of CC bursts (CC_LENGTH+1..65535).
- CC_LENGTH, 5: consecutive CC blocks per burst (1..15).

Ports:
- Clk  in  1  block clock, shared with the priority mux.
- Rst  in  1  asynchronous reset, active-low (asserted at 0).
- TxEnable  in  1  lane enable; 0 forces the init sequence.
- DataAvail  in  1  user data block waiting at the mux Data input.
- UserKReq  in  1  user K-block waiting at the mux UserK input.
- Sent  in  8  one-hot acknowledge from the mux; all-zero means nothing sent this cycle.
- ToSend  out  8  request vector to the mux.
- Ready  out  1  high in RUN state.
- CcPending  out  1  a CC burst is in progress.

Behaviour:
- Reset (Rst=0, async):
  - State = NOT_RDY; all counters = 0; CcPending = 0; Ready = 0.
  - ToSend = NOT_READY bit | IDLE bit.
- Every output is a pure function of registered state. No combinational path from Sent or any other input to an output.
- All counter and state updates occur on the Clk edge where Sent != 0 ("a send"). ToSend is therefore updated in the cycle after the Sent pulse, which is exactly when the mux re-samples ToSend.
- State NOT_RDY:
  - ToSend = {NOT_READY, IDLE}.
  - nr_cnt (16b) increments on each Sent[NOT_READY].
  - On the send that makes nr_cnt reach INIT_NR_BLOCKS: go to BOND and clear nr_cnt.
- State BOND:
  - ToSend = {CHANNEL_BONDING, IDLE}.
  - cb_cnt (16b) increments on each Sent[CHANNEL_BONDING].
  - On reaching CB_BLOCKS: go to RUN, clear cb_cnt, clear blk_cnt.
- State RUN:
  - Ready = 1.
  - blk_cnt (16b) increments on every send and wraps to 0 when it reaches CC_INTERVAL-1.
  - At that wrap: cc_rem (4b) is loaded with CC_LENGTH and CcPending goes to 1.
  - ToSend[CLOCK_COMPENSATION] = (cc_rem != 0).
  - Each Sent[CLOCK_COMPENSATION] decrements cc_rem. CcPending goes to 0 when cc_rem reaches 0.
  - ToSend[USER_DATA] = registered DataAvail.
  - ToSend[USER_KBLOCKS] = registered UserKReq.
  - ToSend[IDLE] = 1.
  - NATIVE_FLOW_CONTROL, USER_FLOW_CONTROL, NOT_READY and CHANNEL_BONDING bits = 0.
  - DataAvail and UserKReq are registered every cycle, giving 1 cycle of latency.
- Boundary conditions:
  - CC wrap while cc_rem != 0 (interval too short): cc_rem is reloaded to CC_LENGTH. The burst is never lost.
  - Multiple bits set in Sent: treated as a protocol error. Counters use the highest-priority set bit only, in the mux priority order.
  - Sent bit that does not match the current request (e.g. Sent[IDLE] in NOT_RDY): counts as a send for blk_cnt only; it does not advance nr_cnt or cb_cnt.
  - TxEnable = 0 in any state: on the next edge, state = NOT_RDY and all counters and cc_rem are cleared. Any in-flight CC burst is abandoned.
  - Rst asserted mid-operation: immediate return to the reset values.
  - blk_cnt never exceeds CC_INTERVAL-1.

Optional Feature:
- Macro: AURORA_TX_CB_EN.
- Defined: BOND state and cb_cnt are present, as described above.
- Undefined: for single-lane builds, BOND and cb_cnt are removed. NOT_RDY transitions directly to RUN on the send that makes nr_cnt reach INIT_NR_BLOCKS, and ToSend[CHANNEL_BONDING] is always 0.

Test Plan:
- Release Rst with TxEnable=1; bench mux model acks every other cycle -> ToSend=NOT_READY|IDLE for exactly 64 Sent[NOT_READY] pulses, then CHANNEL_BONDING|IDLE for 16 pulses, then Ready=1 in the cycle after the 16th.
- RUN with DataAvail=0, Sent[IDLE] each send, CC_INTERVAL=20, CC_LENGTH=3 -> ToSend CC bit rises after the 20th send, stays high for exactly 3 Sent[CC] pulses, repeats every 20 sends.
- RUN with DataAvail=1 and UserKReq pulsed one cycle -> ToSend USER_DATA and USER_KBLOCKS each follow the input with 1-cycle delay. Bench checks the CC bit still asserts on schedule concurrently.
- CC_INTERVAL=5, CC_LENGTH=4, mux never acks CC -> cc_rem reloads to 4 at each wrap and CcPending stays 1.
- TxEnable dropped for one cycle mid-CC-burst in RUN -> next cycle ToSend=NOT_READY|IDLE, Ready=0, CcPending=0, full 64-block init restarts.
- Build without AURORA_TX_CB_EN -> Ready=1 right after the 64th Sent[NOT_READY], and ToSend CHANNEL_BONDING bit is never 1.

Source files
------------

// File: rtl/aurora_tx_scheduler.sv
// Request generator for the Aurora 64b/66b TX priority mux: lane init, bonding and periodic CC bursts.
// Optional macro AURORA_TX_CB_EN keeps the BOND state; without it the lane goes NOT_RDY -> RUN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_NOT_RDY | sending NOT_READY blocks until INIT_NR_BLOCKS have gone out
// ST_BOND    | sending CHANNEL_BONDING blocks until CB_BLOCKS have gone out
// ST_RUN     | lane up: CC bursts every CC_INTERVAL sends, user data/K forwarded
module aurora_tx_scheduler #(
  parameter int unsigned INIT_NR_BLOCKS = 64,
  parameter int unsigned CB_BLOCKS      = 16,
  parameter int unsigned CC_INTERVAL    = 1000,
  parameter int unsigned CC_LENGTH      = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TxEnable,
  input  logic       DataAvail,
  input  logic       UserKReq,
  input  logic [7:0] Sent,
  output logic [7:0] ToSend,
  output logic       Ready,
  output logic       CcPending
);

  // Bit positions in mux priority order (bit 0 wins).
  localparam int CLOCK_COMPENSATION  = 0;
  localparam int NOT_READY           = 1;
  localparam int CHANNEL_BONDING     = 2;
  localparam int NATIVE_FLOW_CONTROL = 3;
  localparam int USER_FLOW_CONTROL   = 4;
  localparam int USER_KBLOCKS        = 5;
  localparam int USER_DATA           = 6;
  localparam int IDLE                = 7;

  localparam logic [15:0] NR_LAST  = 16'(INIT_NR_BLOCKS - 1);
  localparam logic [15:0] BLK_LAST = 16'(CC_INTERVAL - 1);
  localparam logic [3:0]  CC_LOAD  = 4'(CC_LENGTH);

  typedef enum logic [1:0] {
    ST_NOT_RDY = 2'd0,
`ifdef AURORA_TX_CB_EN
    ST_BOND    = 2'd1,
`endif
    ST_RUN     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] nr_cnt_q, nr_cnt_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic [3:0]  cc_rem_q, cc_rem_d;
  logic [7:0]  to_send_d;
  logic        ready_d, cc_pending_d;
  logic        send, top_nr, top_cc;

  // With several Sent bits set only the highest-priority one is honoured.
  assign send   = |Sent;
  assign top_cc = Sent[CLOCK_COMPENSATION];
  assign top_nr = Sent[NOT_READY] & ~Sent[CLOCK_COMPENSATION];

`ifdef AURORA_TX_CB_EN
  localparam logic [15:0] CB_LAST = 16'(CB_BLOCKS - 1);
  logic [15:0] cb_cnt_q, cb_cnt_d;
  logic        top_cb;
  assign top_cb = Sent[CHANNEL_BONDING] & ~Sent[NOT_READY] & ~Sent[CLOCK_COMPENSATION];
`endif

  always_comb begin
    state_d   = state_q;
    nr_cnt_d  = nr_cnt_q;
    blk_cnt_d = blk_cnt_q;
    cc_rem_d  = cc_rem_q;
`ifdef AURORA_TX_CB_EN
    cb_cnt_d  = cb_cnt_q;
`endif
    if (!TxEnable) begin
      state_d   = ST_NOT_RDY;
      nr_cnt_d  = '0;
      blk_cnt_d = '0;
      cc_rem_d  = '0;
`ifdef AURORA_TX_CB_EN
      cb_cnt_d  = '0;
`endif
    end else if (send) begin
      case (state_q)
        ST_NOT_RDY: begin
          if (top_nr) begin
            if (nr_cnt_q == NR_LAST) begin
              nr_cnt_d = '0;
`ifdef AURORA_TX_CB_EN
              state_d  = ST_BOND;
`else
              state_d   = ST_RUN;
              blk_cnt_d = '0;
              cc_rem_d  = '0;
`endif
            end else begin
              nr_cnt_d = nr_cnt_q + 16'd1;
            end
          end
        end
`ifdef AURORA_TX_CB_EN
        ST_BOND: begin
          if (top_cb) begin
            if (cb_cnt_q == CB_LAST) begin
              cb_cnt_d  = '0;
              blk_cnt_d = '0;
              cc_rem_d  = '0;
              state_d   = ST_RUN;
            end else begin
              cb_cnt_d = cb_cnt_q + 16'd1;
            end
          end
        end
`endif
        ST_RUN: begin
          if (top_cc && (cc_rem_q != 4'd0)) cc_rem_d = cc_rem_q - 4'd1;
          // A wrap always reloads, even over an unfinished burst.
          if (blk_cnt_q >= BLK_LAST) begin
            blk_cnt_d = '0;
            cc_rem_d  = CC_LOAD;
          end else begin
            blk_cnt_d = blk_cnt_q + 16'd1;
          end
        end
        default: state_d = ST_NOT_RDY;
      endcase
    end

    to_send_d       = '0;
    to_send_d[IDLE] = 1'b1;
    ready_d         = 1'b0;
    cc_pending_d    = 1'b0;
    case (state_d)
      ST_NOT_RDY: to_send_d[NOT_READY] = 1'b1;
`ifdef AURORA_TX_CB_EN
      ST_BOND:    to_send_d[CHANNEL_BONDING] = 1'b1;
`endif
      ST_RUN: begin
        to_send_d[CLOCK_COMPENSATION] = (cc_rem_d != 4'd0);
        to_send_d[USER_DATA]          = DataAvail;
        to_send_d[USER_KBLOCKS]       = UserKReq;
        ready_d                       = 1'b1;
        cc_pending_d                  = (cc_rem_d != 4'd0);
      end
      default: to_send_d[NOT_READY] = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_NOT_RDY;
      nr_cnt_q  <= '0;
      blk_cnt_q <= '0;
      cc_rem_q  <= '0;
      ToSend    <= 8'((1 << NOT_READY) | (1 << IDLE));
      Ready     <= 1'b0;
      CcPending <= 1'b0;
    end else begin
      state_q   <= state_d;
      nr_cnt_q  <= nr_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      cc_rem_q  <= cc_rem_d;
      ToSend    <= to_send_d;
      Ready     <= ready_d;
      CcPending <= cc_pending_d;
    end
  end

`ifdef AURORA_TX_CB_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) cb_cnt_q <= '0;
    else      cb_cnt_q <= cb_cnt_d;
  end
`endif

endmodule
